// File: rtl/b06_irq_source.sv
// Peer of the b06 interrupt handler: generates the count tick and drives a
// request/hold/release handshake against the handler's status outputs.
module b06_irq_source #(
   parameter int CNT_W      = 4,
   parameter int TICK_LIMIT = 7,
   parameter int HOLD_CYC   = 3,
   parameter int TO_TICKS   = 4,
   parameter int SVC_W      = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             irq_in,
   input  logic [1:0]       cc_mux,
   input  logic [1:0]       uscite,
   input  logic             enable_count,
   input  logic             ackout,
   output logic             eql,
   output logic             cont_eql,
   output logic             served,
   output logic             timeout,
   output logic             intr_seen,
   output logic [SVC_W-1:0] svc_cnt
);

   localparam int TO_W = $clog2(TO_TICKS + 1);
   localparam int HW   = $clog2(HOLD_CYC + 1);

   typedef enum logic [1:0] {
      R_IDLE    = 2'b00,
      R_ASSERT  = 2'b01,
      R_HOLD    = 2'b10,
      R_RELEASE = 2'b11
   } t_state;

   t_state           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cont_eql;
   logic [TO_W-1:0]  r_to_cnt;
   logic [HW-1:0]    r_hold;
   logic             r_eql;
   logic             r_served;
   logic             r_timeout;
   logic             r_intr_seen;
   logic [SVC_W-1:0] r_svc_cnt;

   logic w_tick;
   logic w_accept;
   logic w_unmasked;
   logic w_unused;

   assign w_tick     = r_cont_eql & ~enable_count;
   assign w_accept   = (uscite == 2'b00) && (cc_mux == 2'b11);
   assign w_unmasked = (cc_mux != 2'b00);
   // ackout only matters to the protocol check kept outside the design
   assign w_unused   = ackout;

   // Tick counter: saturates at TICK_LIMIT, rearms once the handler drops enable_count
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_cont_eql <= 1'b0;
      end else if (w_tick) begin
         r_cnt      <= '0;
         r_cont_eql <= 1'b0;
      end else if (r_cnt == CNT_W'(TICK_LIMIT)) begin
         r_cont_eql <= 1'b1;
      end else if (enable_count) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= R_IDLE;
         r_to_cnt    <= '0;
         r_hold      <= '0;
         r_eql       <= 1'b0;
         r_served    <= 1'b0;
         r_timeout   <= 1'b0;
         r_intr_seen <= 1'b0;
         r_svc_cnt   <= '0;
      end else begin
         r_served  <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            R_IDLE: begin
               if (irq_in) begin
                  r_state     <= R_ASSERT;
                  r_to_cnt    <= '0;
                  r_intr_seen <= 1'b0;
                  r_eql       <= w_unmasked;
               end else begin
                  r_eql <= 1'b0;
               end
            end
            R_ASSERT: begin
               // acceptance wins over a timeout landing on the same edge
               if (w_accept) begin
                  r_state <= R_HOLD;
                  r_hold  <= '0;
                  r_eql   <= w_unmasked;
               end else if (w_tick && (r_to_cnt == TO_W'(TO_TICKS - 1))) begin
                  r_state   <= R_IDLE;
                  r_timeout <= 1'b1;
                  r_eql     <= 1'b0;
               end else begin
                  if (w_tick) begin
                     r_to_cnt <= r_to_cnt + TO_W'(1);
                  end
                  r_eql <= w_unmasked;
               end
            end
            R_HOLD: begin
               if (uscite == 2'b11) begin
                  r_intr_seen <= 1'b1;
               end
               r_hold <= r_hold + HW'(1);
               if (r_hold == HW'(HOLD_CYC - 1)) begin
                  r_state <= R_RELEASE;
                  r_eql   <= 1'b0;
               end else begin
                  r_eql <= w_unmasked;
               end
            end
            R_RELEASE: begin
               r_eql <= 1'b0;
               if (uscite == 2'b11) begin
                  r_intr_seen <= 1'b1;
               end
               if (uscite == 2'b01) begin
                  r_state   <= R_IDLE;
                  r_served  <= 1'b1;
                  r_svc_cnt <= r_svc_cnt + SVC_W'(1);
               end
            end
            default: begin
               r_state <= R_IDLE;
               r_eql   <= 1'b0;
            end
         endcase
      end
   end

   assign eql       = r_eql;
   assign cont_eql  = r_cont_eql;
   assign served    = r_served;
   assign timeout   = r_timeout;
   assign intr_seen = r_intr_seen;
   assign svc_cnt   = r_svc_cnt;

endmodule
